// File: rtl/adder_share_arb_pkg.sv
// Shared types for the adder-sharing arbiter.
// FSM state encoding and the fixed adder width.
package adder_share_arb_pkg;

  localparam int W_ADD = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/adder_share_arb_pick.sv
// Round-robin picker: first set req at or after ptr.
// Returns a one-hot winner and its index.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  win_id
);

  logic found;

  // Scan ptr..NREQ-1 first, then wrap to 0..ptr-1.
  always_comb begin
    win    = '0;
    win_id = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && i >= int'(ptr)) begin
        found  = 1'b1;
        win[i] = 1'b1;
        win_id = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && i < int'(ptr)) begin
        found  = 1'b1;
        win[i] = 1'b1;
        win_id = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/carry4bitrip.sv
// 4-bit ripple-carry adder; carry-out is dropped.
// Sum wraps modulo 16.
module carry4bitrip (
  input  logic [3:0] n1,
  input  logic [3:0] n2,
  output logic [3:0] outy
);

  logic cy;

  // Ripple the carry bit by bit from the LSB.
  always_comb begin
    outy = '0;
    cy   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      outy[i] = n1[i] ^ n2[i] ^ cy;
      cy      = (n1[i] & n2[i]) | (cy & (n1[i] ^ n2[i]));
    end
  end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin front end sharing one 4-bit adder.
// Grant latches operands; result leaves on valid/ready.
module adder_share_arb
  import adder_share_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_bus,
  input  logic [NREQ*W-1:0] b_bus,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              busy
);

  if (W != W_ADD) begin : g_w_chk
    $error("adder_share_arb: W must be 4");
  end
  if (NREQ < 1 || NREQ > 8) begin : g_n_chk
    $error("adder_share_arb: NREQ out of range");
  end

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic [IDW-1:0] id_q, id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_sum_q, rsp_sum_d;

  logic [NREQ-1:0] win;
  logic [IDW-1:0]  win_id;
  logic [W-1:0]    sel_a, sel_b;
  logic [W-1:0]    sum;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .win    (win),
    .win_id (win_id)
  );

  carry4bitrip u_add (
    .n1   (op_a_q),
    .n2   (op_b_q),
    .outy (sum)
  );

  // Mux the winner's operands off the buses.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        sel_a = a_bus[i*W +: W];
        sel_b = b_bus[i*W +: W];
      end
    end
  end

  // Next-state logic for IDLE -> ADD -> RESP.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          id_d    = win_id;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        rsp_sum_d   = sum;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
        if (id_q == IDW'(NREQ - 1))
          rr_ptr_d = '0;
        else
          rr_ptr_d = id_q + IDW'(1);
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  // Grant pulses only in the IDLE cycle that captures operands.
  always_comb begin
    gnt = '0;
    if (state_q == ST_IDLE && !rst)
      gnt = win;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb.
// Inputs change at negedge; checks at negedge+1.
module tb_adder_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_sum;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] sum;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  adder_share_arb #(
    .NREQ (4),
    .W    (4),
    .IDW  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_ops(input int i,
                         input logic [3:0] a,
                         input logic [3:0] b);
    a_bus[i*4 +: 4] = a;
    b_bus[i*4 +: 4] = b;
  endtask

  // One isolated request: grant, add, respond.
  task automatic single(input int i,
                        input logic [3:0] a,
                        input logic [3:0] b,
                        input logic [3:0] s);
    logic [3:0] one;
    cyc();
    set_ops(i, a, b);
    one = 4'b0001 << i;
    req = one;
    #1 chk("gnt", gnt, one);
    cyc();
    req = '0;
    #1 chk("gnt_pulse", gnt, 0);
    chk("busy_add", busy, 1);
    chk("vld_add", rsp_valid, 0);
    cyc();
    #1 chk("vld", rsp_valid, 1);
    chk("sum", rsp_sum, s);
    chk("id", rsp_id, i);
    cyc();
    #1 chk("vld_done", rsp_valid, 0);
    chk("busy_idle", busy, 0);
  endtask

  // Scoreboard sampled just before each rising edge.
  always @(negedge clk) begin
    #4;
    if (rst) begin
      sb.delete();
    end else begin
      if (gnt != 4'd0) begin
        for (int i = 0; i < 4; i++) begin
          if (gnt[i]) begin
            exp_t e;
            e.id  = 2'(i);
            e.sum = (a_bus[i*4 +: 4]
                   + b_bus[i*4 +: 4]) & 4'hF;
            sb.push_back(e);
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_extra", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_id", rsp_id, e.id);
          chk("sb_sum", rsp_sum, e.sum);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    req       = '0;
    a_bus     = '0;
    b_bus     = '0;
    rsp_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_busy", busy, 0);
    cyc();
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1 chk("post_rst_gnt", gnt, 0);
      chk("post_rst_busy", busy, 0);
      cyc();
    end

    // Single add, then wrap-around sums
    single(0, 4'b0010, 4'b0011, 4'b0101);
    single(1, 4'b1111, 4'b1111, 4'b1110);
    single(2, 4'b1010, 4'b0111, 4'b0001);
    single(3, 4'b0001, 4'b0001, 4'b0010);

    // Contention: pointer is back at 0
    cyc();
    set_ops(0, 4'd1, 4'd2);
    set_ops(1, 4'd3, 4'd4);
    set_ops(2, 4'd9, 4'd9);
    set_ops(3, 4'd15, 4'd2);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] one;
      one = 4'b0001 << k;
      #1 chk("rr_gnt", gnt, one);
      cyc();
      req = req & ~one;
      #1 chk("rr_nogap", gnt, 0);
      cyc();
      cyc();
    end
    req = 4'b1001;
    #1 chk("rr_re0", gnt, 4'b0001);
    cyc();
    req = 4'b1000;
    cyc();
    cyc();
    #1 chk("rr_re3", gnt, 4'b1000);
    cyc();
    req = '0;
    cyc();
    cyc();

    // Backpressure with a pending request
    set_ops(0, 4'd4, 4'd5);
    set_ops(1, 4'd8, 4'd9);
    rsp_ready = 1'b0;
    req = 4'b0001;
    #1 chk("bp_gnt0", gnt, 4'b0001);
    cyc();
    req = 4'b0010;
    cyc();
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_vld", rsp_valid, 1);
      chk("bp_sum", rsp_sum, 4'd9);
      chk("bp_id", rsp_id, 0);
      chk("bp_nognt", gnt, 0);
      cyc();
    end
    rsp_ready = 1'b1;
    #1 chk("bp_last_nognt", gnt, 0);
    cyc();
    #1 chk("bp_gnt1", gnt, 4'b0010);
    cyc();
    req = '0;
    cyc();
    #1 chk("bp_sum1", rsp_sum, 4'd1);
    chk("bp_id1", rsp_id, 1);
    cyc();

    // Reset during ADD drops the result
    set_ops(0, 4'b0111, 4'b1010);
    req = 4'b0001;
    #1 chk("mr_gnt", gnt, 4'b0001);
    cyc();
    req = '0;
    #1 chk("mr_busy_add", busy, 1);
    rst = 1'b1;
    #1 chk("mr_busy", busy, 0);
    chk("mr_vld", rsp_valid, 0);
    chk("mr_gnt0", gnt, 0);
    cyc();
    rst = 1'b0;
    #1 chk("mr_vld_a", rsp_valid, 0);
    cyc();
    #1 chk("mr_vld_b", rsp_valid, 0);
    chk("mr_gnt_b", gnt, 0);
    single(0, 4'b0111, 4'b1010, 4'b0001);

    cyc();
    cyc();
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
